// File: rtl/wbc_posted_write_bridge.sv
// Classic-to-pipelined Wishbone bridge: posted writes drain from a small
// FIFO in pipelined bursts; reads issue singly behind all posted writes.
`timescale 1ns/1ps
module wbc_posted_write_bridge #(
    parameter int AW     = 30,
    parameter int DW     = 32,
    parameter int LGFIFO = 3
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_scyc,
    input  logic            i_sstb,
    input  logic            i_swe,
    input  logic [AW-1:0]   i_saddr,
    input  logic [DW-1:0]   i_sdata,
    input  logic [DW/8-1:0] i_ssel,
    output logic            o_sack,
    output logic [DW-1:0]   o_sdata,
    output logic            o_serr,
    output logic            o_mcyc,
    output logic            o_mstb,
    output logic            o_mwe,
    output logic [AW-1:0]   o_maddr,
    output logic [DW-1:0]   o_mdata,
    output logic [DW/8-1:0] o_msel,
    input  logic            i_mack,
    input  logic            i_merr,
    input  logic            i_mstall,
    input  logic [DW-1:0]   i_mdata,
    output logic            o_wr_err,
    input  logic            i_err_clr
);
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << LGFIFO;
    localparam logic [LGFIFO:0]   CNT_FULL = (LGFIFO + 1)'(DEPTH);
    localparam logic [LGFIFO:0]   CNT_ONE  = (LGFIFO + 1)'(1);
    localparam logic [LGFIFO-1:0] PTR_ONE  = LGFIFO'(1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RDREQ,
        RDWAIT
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [SW-1:0] fifo_sel  [DEPTH];

    logic [LGFIFO-1:0] wr_ptr, rd_ptr;
    logic [LGFIFO:0]   count, count_nxt;
    logic [LGFIFO:0]   outstanding, outstanding_nxt;

    logic          full, empty, rd_busy;
    logic          push, pop, rd_pend;
    logic          rd_live, rd_ok, rd_bad;
    logic          sack, serr, rd_abort, wr_err;
    logic [DW-1:0] sdata;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_sel;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign rd_busy = (state == RDREQ) || (state == RDWAIT);

    // No push while o_sack is high: the master still holds stb that cycle.
    assign push = i_scyc && i_sstb && i_swe && !full && !sack && !rd_busy;
    assign pop  = (state == WRITE) && !empty && !i_mstall && !i_merr;

    assign rd_pend = i_scyc && i_sstb && !i_swe && !sack && !serr;

    assign rd_live = i_scyc && !rd_abort;
    assign rd_ok   = (state == RDWAIT) && i_mack && !i_merr && rd_live;
    assign rd_bad  = (state == RDWAIT) && i_merr && rd_live;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_ONE;
        else if (pop && !push)
            count_nxt = count - CNT_ONE;
    end

    // Acks outside a write burst, or with nothing in flight, are ignored.
    always_comb begin
        outstanding_nxt = outstanding;
        if (state != WRITE || i_merr)
            outstanding_nxt = '0;
        else if (pop && !(i_mack && outstanding != '0))
            outstanding_nxt = outstanding + CNT_ONE;
        else if (!pop && i_mack && outstanding != '0)
            outstanding_nxt = outstanding - CNT_ONE;
    end

    always_comb begin
        state_nxt = state;
        o_mcyc    = 1'b0;
        o_mstb    = 1'b0;
        o_mwe     = 1'b0;
        o_maddr   = '0;
        o_mdata   = '0;
        o_msel    = '0;
        unique case (state)
            IDLE: begin
                if (!empty || push)
                    state_nxt = WRITE;
                else if (rd_pend && outstanding == '0)
                    state_nxt = RDREQ;
            end
            WRITE: begin
                o_mcyc = 1'b1;
                o_mwe  = 1'b1;
                o_mstb = !empty;
                if (!empty) begin
                    o_maddr = fifo_addr[rd_ptr];
                    o_mdata = fifo_data[rd_ptr];
                    o_msel  = fifo_sel[rd_ptr];
                end
                if (i_merr)
                    state_nxt = IDLE;
                else if (count_nxt == '0 && outstanding_nxt == '0)
                    state_nxt = IDLE;
            end
            RDREQ: begin
                o_mcyc  = 1'b1;
                o_mstb  = 1'b1;
                o_maddr = rd_addr;
                o_msel  = rd_sel;
                if (!i_mstall)
                    state_nxt = RDWAIT;
            end
            RDWAIT: begin
                o_mcyc = 1'b1;
                if (i_mack || i_merr)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            sack        <= 1'b0;
            serr        <= 1'b0;
            sdata       <= '0;
            wr_err      <= 1'b0;
            rd_addr     <= '0;
            rd_sel      <= '0;
            rd_abort    <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            outstanding <= outstanding_nxt;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            sack <= push || rd_ok;
            serr <= rd_bad;
            if (state == RDWAIT && i_mack && !i_merr)
                sdata <= i_mdata;
            // A slave that walks away mid-read gets no completion pulse.
            if (state == IDLE && state_nxt == RDREQ) begin
                rd_addr  <= i_saddr;
                rd_sel   <= i_ssel;
                rd_abort <= 1'b0;
            end else if (rd_busy && !i_scyc) begin
                rd_abort <= 1'b1;
            end
            if (state == WRITE && i_merr)
                wr_err <= 1'b1;
            else if (i_err_clr)
                wr_err <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_saddr;
            fifo_data[wr_ptr] <= i_sdata;
            fifo_sel[wr_ptr]  <= i_ssel;
        end
    end

    assign o_sack   = sack;
    assign o_serr   = serr;
    assign o_sdata  = sdata;
    assign o_wr_err = wr_err;

endmodule

// File: tb/tb_wbc_posted_write_bridge.sv
// Directed bench for wbc_posted_write_bridge with a small pipelined
// downstream responder that logs every issued master transaction.
`timescale 1ns/1ps
module tb_wbc_posted_write_bridge;
    logic        i_clk;
    logic        i_reset;
    logic        i_scyc, i_sstb, i_swe;
    logic [29:0] i_saddr;
    logic [31:0] i_sdata;
    logic [3:0]  i_ssel;
    logic        o_sack, o_serr;
    logic [31:0] o_sdata;
    logic        o_mcyc, o_mstb, o_mwe;
    logic [29:0] o_maddr;
    logic [31:0] o_mdata;
    logic [3:0]  o_msel;
    logic        i_mack, i_merr, i_mstall;
    logic [31:0] i_mdata;
    logic        o_wr_err;
    logic        i_err_clr;

    wbc_posted_write_bridge #(.AW(30), .DW(32), .LGFIFO(3)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_scyc(i_scyc), .i_sstb(i_sstb), .i_swe(i_swe),
        .i_saddr(i_saddr), .i_sdata(i_sdata), .i_ssel(i_ssel),
        .o_sack(o_sack), .o_sdata(o_sdata), .o_serr(o_serr),
        .o_mcyc(o_mcyc), .o_mstb(o_mstb), .o_mwe(o_mwe),
        .o_maddr(o_maddr), .o_mdata(o_mdata), .o_msel(o_msel),
        .i_mack(i_mack), .i_merr(i_merr), .i_mstall(i_mstall),
        .i_mdata(i_mdata), .o_wr_err(o_wr_err), .i_err_clr(i_err_clr)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        int due;
        bit err;
        bit we;
    } rsp_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          burst;
    } wr_t;

    rsp_t rq[$];
    rsp_t r;
    wr_t  wlog[$];

    int cyc = 0;
    int ack_lat = 1;
    int err_at = -1;
    int wr_issue_n = 0;
    int burst = 0;
    bit rd_err = 1'b0;
    bit prev_mcyc = 1'b0;
    int rd_n = 0;
    logic [29:0] rd_addr_seen = '0;
    int rd_issue_cyc = 0;
    int last_wr_ack_cyc = 0;

    int errors = 0;
    int checks = 0;

    // Downstream pipelined slave: acks each issue ack_lat cycles later.
    initial begin
        i_mack  = 1'b0;
        i_merr  = 1'b0;
        i_mdata = '0;
        forever begin
            @(posedge i_clk);
            cyc++;
            #1;
            i_mack  = 1'b0;
            i_merr  = 1'b0;
            i_mdata = '0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                r = rq.pop_front();
                i_merr = r.err;
                i_mack = !r.err;
                if (!r.we)
                    i_mdata = 32'h12345678;
                else if (!r.err)
                    last_wr_ack_cyc = cyc;
            end
            @(negedge i_clk);
            if (o_mcyc && !prev_mcyc)
                burst++;
            prev_mcyc = o_mcyc;
            if (i_reset || !o_mcyc) begin
                rq.delete();
            end else if (o_mstb && !i_mstall) begin
                if (o_mwe) begin
                    wr_issue_n++;
                    wlog.push_back('{o_maddr, o_mdata, o_msel, burst});
                    rq.push_back('{cyc + ack_lat, wr_issue_n == err_at, 1'b1});
                end else begin
                    rd_n++;
                    rd_addr_seen = o_maddr;
                    rd_issue_cyc = cyc;
                    rq.push_back('{cyc + ack_lat, rd_err, 1'b0});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sl_req(input logic we, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        i_scyc  = 1'b1;
        i_sstb  = 1'b1;
        i_swe   = we;
        i_saddr = a;
        i_sdata = d;
        i_ssel  = s;
    endtask

    task automatic sl_end();
        @(posedge i_clk);
        #1;
        i_scyc = 1'b0;
        i_sstb = 1'b0;
        i_swe  = 1'b0;
    endtask

    task automatic wait_ack(input int maxc, output int lat, output bit got);
        lat = -1;
        got = 1'b0;
        for (int k = 1; k <= maxc; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (o_sack || o_serr) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic sl_write(input logic [29:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int lat);
        bit got;
        sl_req(1'b1, a, d, s);
        wait_ack(12, lat, got);
        sl_end();
    endtask

    task automatic wait_wlog(input int n, input int maxc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(negedge i_clk);
            if (wlog.size() >= n && !o_mcyc) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int nack;
        int rd_n0;
        bit got;
        bit ok;
        bit seen;

        i_reset   = 1'b1;
        i_scyc    = 1'b0;
        i_sstb    = 1'b0;
        i_swe     = 1'b0;
        i_saddr   = '0;
        i_sdata   = '0;
        i_ssel    = '0;
        i_mstall  = 1'b0;
        i_err_clr = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("reset_ctl", {o_mcyc, o_mstb, o_mwe, o_sack, o_serr, o_wr_err}, 0);
        chk("reset_maddr", o_maddr, 0);
        chk("reset_mdata", {o_mdata, o_msel}, 0);
        chk("reset_sdata", o_sdata, 0);

        // Single posted write
        @(posedge i_clk);
        #1;
        wlog.delete();
        sl_req(1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
        wait_ack(4, lat, got);
        chk("wr_ack_lat", lat, 1);
        chk("wr_first_stb", {o_mcyc, o_mstb, o_mwe}, 3'b111);
        chk("wr_maddr", o_maddr, 30'h10);
        chk("wr_mdata", o_mdata, 32'hDEADBEEF);
        chk("wr_msel", o_msel, 4'hF);
        sl_end();
        @(negedge i_clk);
        chk("wr_ack_cycle", {i_mack, o_mcyc, o_mstb, o_sack}, 4'b1100);
        @(negedge i_clk);
        chk("wr_cyc_drop", o_mcyc, 0);
        chk("wr_count", wlog.size(), 1);

        // Nine writes against a stalled master: FIFO fills at eight
        wlog.delete();
        i_mstall = 1'b1;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            sl_write(30'(32'h100 + i), 32'hA0000000 + i, 4'(i + 1), lat);
            if (lat == 1)
                nack++;
        end
        chk("full_acks", nack, 8);
        sl_req(1'b1, 30'h108, 32'hA0000008, 4'h9);
        wait_ack(5, lat, got);
        chk("full_hold", got, 0);
        chk("stall_stb", {o_mcyc, o_mstb, o_mwe}, 3'b111);
        chk("stall_maddr", o_maddr, 30'h100);
        chk("stall_mdata", o_mdata, 32'hA0000000);
        chk("stall_none_issued", wlog.size(), 0);
        @(posedge i_clk);
        #1;
        i_mstall = 1'b0;
        wait_ack(6, lat, got);
        chk("full_ack_after_space", got, 1);
        sl_end();
        wait_wlog(9, 40, ok);
        chk("full_drain", ok, 1);
        for (int i = 0; i < 9; i++)
            chk("full_order", wlog[i].addr, 30'(32'h100 + i));
        chk("full_9th_data", wlog[8].data, 32'hA0000008);
        chk("full_9th_sel", wlog[8].sel, 4'h9);

        // Read ordered behind three posted writes, slow acks
        @(posedge i_clk);
        #1;
        ack_lat = 4;
        wlog.delete();
        rd_n = 0;
        for (int i = 0; i < 3; i++)
            sl_write(30'(32'h20 + i), 32'hC0000000 + i, 4'hF, lat);
        sl_req(1'b0, 30'h22, 32'h0, 4'hF);
        wait_ack(60, lat, got);
        chk("rd_sack", {o_sack, o_serr}, 2'b10);
        chk("rd_sdata", o_sdata, 32'h12345678);
        chk("rd_after_last_wr_ack", rd_issue_cyc > last_wr_ack_cyc, 1);
        chk("rd_addr", rd_addr_seen, 30'h22);
        sl_end();
        @(negedge i_clk);
        chk("rd_single_pulse", o_sack, 0);
        chk("rd_count", rd_n, 1);
        chk("rd_wr_count", wlog.size(), 3);

        // Read on an idle bridge, zero stall
        @(posedge i_clk);
        #1;
        ack_lat = 1;
        sl_req(1'b0, 30'h40, 32'h0, 4'h3);
        wait_ack(8, lat, got);
        chk("rd_idle_lat", lat, 3);
        chk("rd_idle_addr", rd_addr_seen, 30'h40);
        sl_end();

        // Error on the 2nd of 4 posted writes
        wlog.delete();
        err_at = wr_issue_n + 2;
        for (int i = 0; i < 4; i++)
            sl_write(30'(32'h50 + i), 32'hE0000000 + i, 4'hF, lat);
        wait_wlog(4, 30, ok);
        err_at = -1;
        chk("err_drain", ok, 1);
        chk("err_flag", o_wr_err, 1);
        chk("err_no_retry", wlog.size(), 4);
        chk("err_new_cycle", wlog[2].burst > wlog[1].burst, 1);
        chk("err_w4_addr", wlog[3].addr, 30'h53);
        @(posedge i_clk);
        #1;
        i_err_clr = 1'b1;
        @(posedge i_clk);
        #1;
        i_err_clr = 1'b0;
        @(negedge i_clk);
        chk("err_clr", o_wr_err, 0);

        // Read answered with an error
        @(posedge i_clk);
        #1;
        rd_err = 1'b1;
        sl_req(1'b0, 30'h60, 32'h0, 4'hF);
        wait_ack(8, lat, got);
        chk("rerr_serr", {o_serr, o_sack}, 2'b10);
        chk("rerr_sdata", o_sdata, 32'h12345678);
        sl_end();
        @(negedge i_clk);
        chk("rerr_pulse", o_serr, 0);
        rd_err = 1'b0;

        // Slave abandons a read while it waits on the master side
        @(posedge i_clk);
        #1;
        ack_lat = 4;
        rd_n0 = rd_n;
        sl_req(1'b0, 30'h70, 32'h0, 4'hF);
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_scyc = 1'b0;
        i_sstb = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            if (o_sack || o_serr)
                seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_issued", rd_n - rd_n0, 1);
        chk("abort_done", o_mcyc, 0);

        // Reset with 2 outstanding and 3 queued writes
        @(posedge i_clk);
        #1;
        ack_lat = 20;
        wlog.delete();
        sl_write(30'h80, 32'hF0000000, 4'hF, lat);
        sl_write(30'h81, 32'hF0000001, 4'hF, lat);
        i_mstall = 1'b1;
        for (int i = 2; i < 5; i++)
            sl_write(30'(32'h80 + i), 32'hF0000000 + i, 4'hF, lat);
        chk("pre_rst_issued", wlog.size(), 2);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("rst_ctl", {o_mcyc, o_mstb, o_mwe, o_sack, o_serr, o_wr_err}, 0);
        chk("rst_maddr", o_maddr, 0);
        chk("rst_mdata", {o_mdata, o_msel}, 0);
        chk("rst_sdata", o_sdata, 0);
        @(posedge i_clk);
        #1;
        ack_lat = 1;
        i_mstall = 1'b0;
        wlog.delete();
        repeat (2) @(posedge i_clk);
        #1;
        sl_write(30'h90, 32'h0BADF00D, 4'h5, lat);
        wait_wlog(1, 20, ok);
        repeat (5) @(negedge i_clk);
        chk("post_rst_only", wlog.size(), 1);
        chk("post_rst_addr", wlog[0].addr, 30'h90);
        chk("post_rst_data", wlog[0].data, 32'h0BADF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
